// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_pkg
//  Purpose  : Shared types, sizes and request-scan helpers for the elevator
//             car controller.
//  Revision : 1.0  initial release
// ============================================================================
package elevator_pkg;

    localparam int FLOOR_W    = 4;
    localparam int MAX_FLOORS = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_e;

    // True when any request sits strictly above the given floor.
    function automatic logic req_above(input logic [MAX_FLOORS-1:0] pend,
                                       input logic [FLOOR_W-1:0]    floor);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i > int'(floor)) begin
                r = r | pend[i];
            end
        end
        return r;
    endfunction

    // True when any request sits strictly below the given floor.
    function automatic logic req_below(input logic [MAX_FLOORS-1:0] pend,
                                       input logic [FLOOR_W-1:0]    floor);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i < int'(floor)) begin
                r = r | pend[i];
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/elevator_car_controller_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : cycle_timer
//  Purpose  : Restartable cycle counter. A start pulse begins a run of LEN
//             cycles (count 0..LEN-1); busy is high for the whole run and
//             done flags the terminal count (meaningful only while busy).
//  Revision : 1.0  initial release
// ============================================================================
module cycle_timer #(
    parameter int LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done
);

    localparam int              CNT_W      = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(LEN - 1);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_busy_q;
    logic             w_busy_d;

    // Next count: start (re)loads zero and wins over the terminal count.
    always_comb begin
        w_cnt_d  = r_cnt_q;
        w_busy_d = r_busy_q;
        if (start) begin
            w_cnt_d  = '0;
            w_busy_d = 1'b1;
        end else if (r_busy_q) begin
            if (r_cnt_q == c_last_cnt) begin
                w_cnt_d  = '0;
                w_busy_d = 1'b0;
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    // Counter and run-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q  <= '0;
            r_busy_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_busy_q <= w_busy_d;
        end
    end

    assign busy = r_busy_q;
    assign done = (r_cnt_q == c_last_cnt);

endmodule
`default_nettype wire

// File: rtl/elevator_car_controller.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_car_controller
//  Purpose  : Latches floor calls, schedules car travel in collective (SCAN)
//             order, times floor-to-floor travel and door dwell, and drives
//             the registered floor code and motion/door status.
//  Revision : 1.0  initial release
// ============================================================================
module elevator_car_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 10,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    state_e                  r_state_q;
    state_e                  w_state_d;
    logic [FLOOR_W-1:0]      r_floor_q;
    logic [FLOOR_W-1:0]      w_floor_d;
    logic                    r_dir_up_q;
    logic                    w_dir_up_d;
    logic [NUM_FLOORS-1:0]   r_pending_q;
    logic [NUM_FLOORS-1:0]   w_pending_d;
    logic                    r_moving_up_q;
    logic                    r_moving_down_q;
    logic                    r_door_open_q;

    logic [MAX_FLOORS-1:0]   w_pend_ext;
    logic [MAX_FLOORS-1:0]   w_call_ext;
    logic [MAX_FLOORS-1:0]   w_clr;
    logic [MAX_FLOORS-1:0]   w_mask;
    logic [FLOOR_W-1:0]      w_floor_up;
    logic [FLOOR_W-1:0]      w_floor_dn;
    logic                    w_any_above;
    logic                    w_any_below;

    logic                    w_trav_start;
    logic                    w_trav_busy;
    logic                    w_trav_done;
    logic                    w_dwell_start;
    logic                    w_dwell_busy;
    logic                    w_dwell_done;

    // Floors beyond NUM_FLOORS read as zero so floor-indexed lookups stay in range.
    assign w_pend_ext  = MAX_FLOORS'(r_pending_q);
    assign w_call_ext  = MAX_FLOORS'(call_req);
    assign w_floor_up  = r_floor_q + 1'b1;
    assign w_floor_dn  = r_floor_q - 1'b1;
    assign w_any_above = req_above(w_pend_ext, r_floor_q);
    assign w_any_below = req_below(w_pend_ext, r_floor_q);

    cycle_timer #(
        .LEN   (TRAVEL_CYCLES)
    ) u_travel_timer (
        .clk   (clk),
        .rst   (rst),
        .start (w_trav_start),
        .busy  (w_trav_busy),
        .done  (w_trav_done)
    );

    cycle_timer #(
        .LEN   (DOOR_CYCLES)
    ) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .start (w_dwell_start),
        .busy  (w_dwell_busy),
        .done  (w_dwell_done)
    );

    // Scheduler: next state, floor, direction, request clears and timer starts.
    always_comb begin
        w_state_d     = r_state_q;
        w_floor_d     = r_floor_q;
        w_dir_up_d    = r_dir_up_q;
        w_clr         = '0;
        w_mask        = '0;
        w_trav_start  = 1'b0;
        w_dwell_start = 1'b0;
        case (r_state_q)
            IDLE: begin
                if (w_pend_ext[r_floor_q]) begin
                    w_state_d          = DOOR_OPEN;
                    w_clr[r_floor_q]   = 1'b1;
                    w_dwell_start      = 1'b1;
                end else if (w_any_above && (r_dir_up_q || !w_any_below)) begin
                    w_state_d    = MOVE_UP;
                    w_dir_up_d   = 1'b1;
                    w_trav_start = 1'b1;
                end else if (w_any_below) begin
                    w_state_d    = MOVE_DOWN;
                    w_dir_up_d   = 1'b0;
                    w_trav_start = 1'b1;
                end
            end
            MOVE_UP: begin
                if (w_trav_busy && w_trav_done) begin
                    w_floor_d = w_floor_up;
                    if (w_pend_ext[w_floor_up]) begin
                        w_state_d         = DOOR_OPEN;
                        w_clr[w_floor_up] = 1'b1;
                        w_dwell_start     = 1'b1;
                    end else if (req_above(w_pend_ext, w_floor_up)) begin
                        w_trav_start = 1'b1;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            MOVE_DOWN: begin
                if (w_trav_busy && w_trav_done) begin
                    w_floor_d = w_floor_dn;
                    if (w_pend_ext[w_floor_dn]) begin
                        w_state_d         = DOOR_OPEN;
                        w_clr[w_floor_dn] = 1'b1;
                        w_dwell_start     = 1'b1;
                    end else if (req_below(w_pend_ext, w_floor_dn)) begin
                        w_trav_start = 1'b1;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
            end
            DOOR_OPEN: begin
                // A call at the open floor extends the dwell instead of queueing.
                w_mask[r_floor_q] = 1'b1;
                if (w_call_ext[r_floor_q]) begin
                    w_dwell_start = 1'b1;
                end else if (w_dwell_busy && w_dwell_done) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // Request latch: new calls set bits, a same-cycle clear wins.
    always_comb begin
        w_pending_d = (r_pending_q | (call_req & ~w_mask[NUM_FLOORS-1:0]))
                      & ~w_clr[NUM_FLOORS-1:0];
    end

    // State, position and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q       <= IDLE;
            r_floor_q       <= '0;
            r_dir_up_q      <= 1'b1;
            r_pending_q     <= '0;
            r_moving_up_q   <= 1'b0;
            r_moving_down_q <= 1'b0;
            r_door_open_q   <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_floor_q       <= w_floor_d;
            r_dir_up_q      <= w_dir_up_d;
            r_pending_q     <= w_pending_d;
            r_moving_up_q   <= (w_state_d == MOVE_UP);
            r_moving_down_q <= (w_state_d == MOVE_DOWN);
            r_door_open_q   <= (w_state_d == DOOR_OPEN);
        end
    end

    assign current_floor = r_floor_q;
    assign moving_up     = r_moving_up_q;
    assign moving_down   = r_moving_down_q;
    assign door_open     = r_door_open_q;
    assign pending       = r_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_elevator_car_controller
//  Purpose  : Self-checking bench for elevator_car_controller. Expected door
//             floors are queued as calls are placed and matched against each
//             door opening; scenario tasks check timing inline.
//  Revision : 1.0  initial release
// ============================================================================
module tb_elevator_car_controller;

    localparam int NF = 10;

    logic          clk;
    logic          rst;
    logic [NF-1:0] call_req;
    logic [3:0]    current_floor;
    logic          moving_up;
    logic          moving_down;
    logic          door_open;
    logic [NF-1:0] pending;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    logic door_prev = 1'b0;

    elevator_car_controller #(
        .NUM_FLOORS    (NF),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .call_req      (call_req),
        .current_floor (current_floor),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .door_open     (door_open),
        .pending       (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard and invariant monitor, sampled 2 time units after each edge.
    always @(posedge clk) begin
        #2;
        if (!rst) begin
            checks++;
            if ((int'(moving_up) + int'(moving_down) + int'(door_open)) > 1) begin
                errors++;
                $display("FAIL status_exclusive: got up=%0b down=%0b door=%0b expected at most one high",
                         moving_up, moving_down, door_open);
            end
            checks++;
            if (int'(current_floor) >= NF) begin
                errors++;
                $display("FAIL floor_range: got %0d expected < %0d", current_floor, NF);
            end
            if (door_open && !door_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL door_order: door opened at floor %0d expected no opening", current_floor);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(current_floor) !== e) begin
                        errors++;
                        $display("FAIL door_order: opened at floor %0d expected floor %0d", current_floor, e);
                    end
                end
            end
        end
        door_prev = door_open;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int f);
        call_req    = '0;
        call_req[f] = 1'b1;
        tick(1);
        call_req    = '0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n;
        n = 0;
        while (!(pending == '0 && !moving_up && !moving_down && !door_open) && n < max_cycles) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= max_cycles) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles expected idle", name, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        call_req = '0;
        tick(2);
        checks++;
        if (current_floor !== 4'd0 || pending !== '0 || {moving_up, moving_down, door_open} !== 3'b000) begin
            errors++;
            $display("FAIL reset_values: got floor=%0d pend=%h st=%b expected 0/0/000",
                     current_floor, pending, {moving_up, moving_down, door_open});
        end
        rst = 1'b0;
        tick(1);
        checks++;
        if ({moving_up, moving_down, door_open} !== 3'b000 || current_floor !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle: got floor=%0d st=%b expected 0/000",
                     current_floor, {moving_up, moving_down, door_open});
        end
        pulse(5);
        checks++;
        if (pending !== 10'h020) begin
            errors++;
            $display("FAIL midtravel_latch: got pend=%h expected 020", pending);
        end
        tick(1);
        checks++;
        if (moving_up !== 1'b1) begin
            errors++;
            $display("FAIL midtravel_start: got moving_up=%0b expected 1", moving_up);
        end
        tick(8);
        checks++;
        if (current_floor !== 4'd2 || moving_up !== 1'b1) begin
            errors++;
            $display("FAIL midtravel_floor2: got floor=%0d up=%0b expected 2/1", current_floor, moving_up);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++;
        if (current_floor !== 4'd0 || pending !== '0 || {moving_up, moving_down, door_open} !== 3'b000) begin
            errors++;
            $display("FAIL midtravel_reset: got floor=%0d pend=%h st=%b expected 0/0/000",
                     current_floor, pending, {moving_up, moving_down, door_open});
        end
        tick(1);
        checks++;
        if ({moving_up, moving_down, door_open} !== 3'b000) begin
            errors++;
            $display("FAIL midtravel_stays_idle: got st=%b expected 000", {moving_up, moving_down, door_open});
        end
    endtask

    task automatic test_single_call;
        exp_q.push_back(3);
        pulse(3);
        checks++;
        if (pending !== 10'h008) begin
            errors++;
            $display("FAIL call3_latch: got pend=%h expected 008", pending);
        end
        tick(1);
        checks++;
        if (moving_up !== 1'b1 || current_floor !== 4'd0) begin
            errors++;
            $display("FAIL call3_depart: got up=%0b floor=%0d expected 1/0", moving_up, current_floor);
        end
        for (int f = 1; f <= 3; f++) begin
            tick(4);
            checks++;
            if (int'(current_floor) !== f) begin
                errors++;
                $display("FAIL call3_step: got floor=%0d expected %0d", current_floor, f);
            end
        end
        checks++;
        if (door_open !== 1'b1 || moving_up !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL call3_arrive: got door=%0b up=%0b pend=%h expected 1/0/000",
                     door_open, moving_up, pending);
        end
        tick(2);
        checks++;
        if (door_open !== 1'b1) begin
            errors++;
            $display("FAIL call3_dwell: got door=%0b expected 1", door_open);
        end
        tick(1);
        checks++;
        if ({moving_up, moving_down, door_open} !== 3'b000) begin
            errors++;
            $display("FAIL call3_close: got st=%b expected 000", {moving_up, moving_down, door_open});
        end
    endtask

    task automatic test_same_floor;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.push_back(0);
        pulse(0);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (door_open !== 1'b1 || pending[0] !== 1'b0) begin
                errors++;
                $display("FAIL same_floor_dwell%0d: got door=%0b pend0=%0b expected 1/0", i, door_open, pending[0]);
            end
            tick(1);
        end
        checks++;
        if (door_open !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL same_floor_close: got door=%0b pend=%h expected 0/000", door_open, pending);
        end
    endtask

    task automatic test_sweep;
        exp_q.push_back(5);
        pulse(5);
        wait_idle(100, "sweep_reach5");
        exp_q.push_back(6);
        exp_q.push_back(8);
        exp_q.push_back(2);
        pulse(8);
        tick(1);
        call_req    = '0;
        call_req[2] = 1'b1;
        call_req[6] = 1'b1;
        tick(1);
        call_req    = '0;
        wait_idle(300, "sweep_serve");
        checks++;
        if (current_floor !== 4'd2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL sweep_end: got floor=%0d left=%0d expected 2/0", current_floor, exp_q.size());
        end
    endtask

    task automatic test_bounds;
        exp_q.push_back(4);
        pulse(4);
        wait_idle(100, "bounds_reach4");
        exp_q.push_back(9);
        exp_q.push_back(0);
        call_req    = '0;
        call_req[9] = 1'b1;
        call_req[0] = 1'b1;
        tick(1);
        call_req    = '0;
        wait_idle(400, "bounds_serve");
        checks++;
        if (current_floor !== 4'd0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bounds_end: got floor=%0d left=%0d expected 0/0", current_floor, exp_q.size());
        end
    endtask

    task automatic test_dwell_extend;
        int n;
        exp_q.push_back(6);
        pulse(6);
        n = 0;
        while (door_open !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL dwell_arrive: door never opened in %0d cycles expected open", n);
        end
        tick(1);
        call_req    = '0;
        call_req[6] = 1'b1;
        tick(1);
        call_req    = '0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (door_open !== 1'b1 || pending[6] !== 1'b0) begin
                errors++;
                $display("FAIL dwell_extend%0d: got door=%0b pend6=%0b expected 1/0", i, door_open, pending[6]);
            end
            tick(1);
        end
        checks++;
        if (door_open !== 1'b0 || pending !== '0) begin
            errors++;
            $display("FAIL dwell_close: got door=%0b pend=%h expected 0/000", door_open, pending);
        end
    endtask

    initial begin
        rst      = 1'b1;
        call_req = '0;
        test_reset();
        test_single_call();
        test_same_floor();
        test_sweep();
        test_bounds();
        test_dwell_extend();
        tick(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
